// File: rtl/sevga_vram_readback.sv
// SE-VGA VRAM CPU read-back port: answers 68000 reads in the card window
// by fetching hi byte from CE0 and lo byte from CE1 in free video slots.
module sevga_vram_readback #(
  parameter logic [7:0] WIN_BASE = 8'hFC,
  parameter int         SYNC_LEN = 2
) (
  input  logic        pixClk,
  input  logic        nReset,
  input  logic [23:1] cpuAddr,
  input  logic        ncpuAS,
  input  logic        ncpuUDS,
  input  logic        ncpuLDS,
  input  logic        cpuRnW,
  input  logic        vidActive,
  input  logic [2:0]  vidSeq,
  input  logic [7:0]  vramDataIn,
  output logic [14:0] rdAddr,
  output logic        nrdOE,
  output logic        nrdCE0,
  output logic        nrdCE1,
  output logic [15:0] cpuDataOut,
  output logic        cpuDataOE,
  output logic        nDTACK
);

  typedef enum logic [1:0] {
    IDLE,
    RD_HI,
    RD_LO,
    ACK
  } state_t;

  state_t state;
  state_t stateNext;

  logic [SYNC_LEN-1:0] asSync;
  logic [SYNC_LEN-1:0] udsSync;
  logic [SYNC_LEN-1:0] ldsSync;
  logic asS;
  logic udsS;
  logic ldsS;

  logic hit;
  logic slotOk;
  logic startRd;
  logic latchHi;
  logic latchLo;
  logic reading;

  logic [7:0] dataHi;
  logic [7:0] dataLo;

  always_ff @(negedge pixClk or negedge nReset) begin
    if (!nReset) begin
      asSync  <= '1;
      udsSync <= '1;
      ldsSync <= '1;
    end else begin
      asSync  <= {asSync[SYNC_LEN-2:0], ncpuAS};
      udsSync <= {udsSync[SYNC_LEN-2:0], ncpuUDS};
      ldsSync <= {ldsSync[SYNC_LEN-2:0], ncpuLDS};
    end
  end

  assign asS  = asSync[SYNC_LEN-1];
  assign udsS = udsSync[SYNC_LEN-1];
  assign ldsS = ldsSync[SYNC_LEN-1];

  assign hit = !asS && cpuRnW
            && (cpuAddr[23:16] == WIN_BASE)
            && (!udsS || !ldsS);

  // Slots 1..4 leave room for both byte reads before slot 0.
  assign slotOk = !vidActive
               || ((vidSeq >= 3'd1) && (vidSeq <= 3'd4));

  always_comb begin
    stateNext = state;
    startRd   = 1'b0;
    latchHi   = 1'b0;
    latchLo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit && slotOk) begin
          startRd   = 1'b1;
          stateNext = !udsS ? RD_HI : RD_LO;
        end
      end
      RD_HI: begin
        if (asS) begin
          stateNext = IDLE;
        end else begin
          latchHi   = 1'b1;
          stateNext = !ldsS ? RD_LO : ACK;
        end
      end
      RD_LO: begin
        if (asS) begin
          stateNext = IDLE;
        end else begin
          latchLo   = 1'b1;
          stateNext = ACK;
        end
      end
      ACK: begin
        if (asS) stateNext = IDLE;
      end
    endcase
  end

  always_ff @(negedge pixClk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(negedge pixClk or negedge nReset) begin
    if (!nReset) begin
      dataHi <= 8'hFF;
      dataLo <= 8'hFF;
    end else if (startRd) begin
      dataHi <= 8'hFF;
      dataLo <= 8'hFF;
    end else begin
      if (latchHi) dataHi <= vramDataIn;
      if (latchLo) dataLo <= vramDataIn;
    end
  end

  assign reading    = (state == RD_HI) || (state == RD_LO);
  assign rdAddr     = reading ? cpuAddr[15:1] : 15'd0;
  assign nrdOE      = !reading;
  assign nrdCE0     = (state != RD_HI);
  assign nrdCE1     = (state != RD_LO);
  assign nDTACK     = (state != ACK);
  assign cpuDataOE  = (state == ACK);
  assign cpuDataOut = {dataHi, dataLo};

endmodule

// File: tb/tb_sevga_vram_readback.sv
// Bench for sevga_vram_readback: timeline model of each CPU bus cycle
// against a VRAM image, randomized cycles plus fixed scenario pins.
`timescale 1ns/1ps
module tb_sevga_vram_readback;

  logic        pixClk;
  logic        nReset;
  logic [23:1] cpuAddr;
  logic        ncpuAS;
  logic        ncpuUDS;
  logic        ncpuLDS;
  logic        cpuRnW;
  logic        vidActive;
  logic [2:0]  vidSeq;
  logic [7:0]  vramDataIn;
  logic [14:0] rdAddr;
  logic        nrdOE;
  logic        nrdCE0;
  logic        nrdCE1;
  logic [15:0] cpuDataOut;
  logic        cpuDataOE;
  logic        nDTACK;

  logic [3:0] hCount;
  logic [7:0] ce0 [0:32767];
  logic [7:0] ce1 [0:32767];

  int checks;
  int failures;

  sevga_vram_readback dut (
    .pixClk(pixClk),
    .nReset(nReset),
    .cpuAddr(cpuAddr),
    .ncpuAS(ncpuAS),
    .ncpuUDS(ncpuUDS),
    .ncpuLDS(ncpuLDS),
    .cpuRnW(cpuRnW),
    .vidActive(vidActive),
    .vidSeq(vidSeq),
    .vramDataIn(vramDataIn),
    .rdAddr(rdAddr),
    .nrdOE(nrdOE),
    .nrdCE0(nrdCE0),
    .nrdCE1(nrdCE1),
    .cpuDataOut(cpuDataOut),
    .cpuDataOE(cpuDataOE),
    .nDTACK(nDTACK)
  );

  initial begin
    pixClk = 1'b0;
    forever #20 pixClk = ~pixClk;
  end

  initial begin
    hCount = 4'd0;
    forever begin
      @(posedge pixClk);
      hCount = hCount + 4'd1;
    end
  end

  assign vidSeq = hCount[3:1];

  assign vramDataIn = !nrdCE0 ? ce0[rdAddr]
                    : !nrdCE1 ? ce1[rdAddr]
                    : 8'hFF;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One CPU bus cycle. Strobes fall between edge 0 and 1; the FSM sees
  // them from edge 3 and sees their release 3 edges after they rise.
  task automatic busCycle(
    input  logic [23:0] a,
    input  logic        rnw,
    input  logic        u,
    input  logic        l,
    input  logic        va,
    input  int          abortR,
    input  int          waitSeq,
    output int          ackEdge,
    output logic [15:0] ackData,
    output int          firstSeq,
    output logic [14:0] addrSeen,
    output int          ce0Cnt,
    output int          ce1Cnt
  );
    int   r;
    int   k;
    int   s;
    int   ph;
    int   nReads;
    logic hitS;
    logic started;
    logic ended;
    logic seen;
    logic sl;
    logic [19:0] expCtl;
    logic [19:0] actCtl;
    logic [15:0] expData;
    logic [14:0] wa;

    ackEdge  = 0;
    ackData  = 16'h0;
    firstSeq = -1;
    addrSeen = 15'h0;
    ce0Cnt   = 0;
    ce1Cnt   = 0;
    wa       = a[15:1];
    hitS     = rnw && (a[23:16] == 8'hFC) && (u || l);
    nReads   = int'(u) + int'(l);
    expData  = {u ? ce0[wa] : 8'hFF, l ? ce1[wa] : 8'hFF};
    r        = abortR;
    started  = 1'b0;
    ended    = 1'b0;
    s        = 0;

    @(posedge pixClk);
    #1;
    if (waitSeq >= 0) begin
      while (int'(vidSeq) != waitSeq) begin
        @(posedge pixClk);
        #1;
      end
    end
    vidActive = va;
    cpuAddr   = a[23:1];
    cpuRnW    = rnw;
    ncpuAS    = 1'b0;
    ncpuUDS   = !u;
    ncpuLDS   = !l;

    k = 0;
    while (!(r > 0 && k >= r + 4)) begin
      @(negedge pixClk);
      #1;
      k++;
      if (k > 200) begin
        failures++;
        $display("FAIL timeout cycle addr=%0h actual=running required=done", a);
        break;
      end
      sl   = !vidActive || (vidSeq >= 3'd1 && vidSeq <= 3'd4);
      seen = (k >= 3) && (r == 0 || k <= r + 2);
      if (!started && !ended && hitS && seen && sl) begin
        started = 1'b1;
        s = k;
      end else if (started && !seen) begin
        started = 1'b0;
        ended   = 1'b1;
      end
      if (!started)             ph = 0;
      else if (k - s >= nReads) ph = 3;
      else if (k == s && u)     ph = 1;
      else                      ph = 2;

      expCtl = {(ph == 1 || ph == 2) ? 1'b0 : 1'b1,
                ph != 1, ph != 2, ph != 3, ph == 3,
                (ph == 1 || ph == 2) ? wa : 15'd0};
      actCtl = {nrdOE, nrdCE0, nrdCE1, nDTACK, cpuDataOE, rdAddr};
      chk("ctrl", 64'(actCtl), 64'(expCtl));
      if (ph == 3) chk("data", 64'(cpuDataOut), 64'(expData));
      if (!nrdOE && vidActive)
        chk("slot", 64'(vidSeq == 3'd7 || vidSeq == 3'd0), 64'd0);

      if (!nDTACK && ackEdge == 0) begin
        ackEdge = k;
        ackData = cpuDataOut;
      end
      if (!nrdOE && firstSeq < 0) begin
        firstSeq = int'(vidSeq);
        addrSeen = rdAddr;
      end
      if (!nrdCE0) ce0Cnt++;
      if (!nrdCE1) ce1Cnt++;

      if (r == 0) begin
        if (ph == 3)              r = k + int'($urandom_range(0, 3));
        else if (!hitS && k == 5) r = k;
      end
      if (k == r) begin
        ncpuAS  = 1'b1;
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
      end
    end
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
  endtask

  int          ackE;
  logic [15:0] ackD;
  int          fSeq;
  logic [14:0] aSeen;
  int          c0;
  int          c1;
  logic [7:0]  hi;
  logic [23:0] ra;
  logic        rnwR;
  logic        uR;
  logic        lR;
  logic        vaR;
  int          abR;

  initial begin
    checks    = 0;
    failures  = 0;
    for (int i = 0; i < 32768; i++) begin
      ce0[i] = 8'($urandom);
      ce1[i] = 8'($urandom);
    end
    ce0[15'h091A] = 8'hA5;
    ce1[15'h091A] = 8'h3C;
    ce0[15'h1000] = 8'h81;

    nReset    = 1'b0;
    cpuAddr   = 23'h7E091A;
    cpuRnW    = 1'b1;
    ncpuAS    = 1'b0;
    ncpuUDS   = 1'b0;
    ncpuLDS   = 1'b0;
    vidActive = 1'b0;
    repeat (4) @(negedge pixClk);
    #1;
    chk("rst_dtack", 64'(nDTACK), 64'd1);
    chk("rst_oe", 64'(cpuDataOE), 64'd0);
    chk("rst_rdoe", 64'(nrdOE), 64'd1);
    chk("rst_data", 64'(cpuDataOut), 64'hFFFF);
    chk("rst_addr", 64'({nrdCE0, nrdCE1, rdAddr}), 64'({2'b11, 15'd0}));
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    @(posedge pixClk);
    #1;
    nReset = 1'b1;
    repeat (3) @(negedge pixClk);

    busCycle(24'hFC1234, 1, 1, 1, 0, 0, -1, ackE, ackD, fSeq, aSeen, c0, c1);
    chk("word_ack_edge", 64'(ackE), 64'd5);
    chk("word_data", 64'(ackD), 64'hA53C);
    chk("word_addr", 64'(aSeen), 64'h091A);

    busCycle(24'hFC2000, 1, 1, 0, 0, 0, -1, ackE, ackD, fSeq, aSeen, c0, c1);
    chk("upper_ack_edge", 64'(ackE), 64'd4);
    chk("upper_data", 64'(ackD), 64'h81FF);
    chk("upper_strobes", 64'({c0[7:0], c1[7:0]}), 64'h0100);

    busCycle(24'hFC1234, 1, 1, 1, 1, 0, 6, ackE, ackD, fSeq, aSeen, c0, c1);
    chk("vid_first_seq", 64'(fSeq), 64'd1);
    chk("vid_data", 64'(ackD), 64'hA53C);

    busCycle(24'hFC1234, 1, 1, 1, 0, 1, -1, ackE, ackD, fSeq, aSeen, c0, c1);
    chk("abort_no_ack", 64'(ackE), 64'd0);
    chk("abort_strobes", 64'({c0[7:0], c1[7:0]}), 64'h0100);

    busCycle(24'hFB0000, 1, 1, 1, 0, 0, -1, ackE, ackD, fSeq, aSeen, c0, c1);
    chk("outwin_no_ack", 64'(ackE), 64'd0);
    chk("outwin_strobes", 64'(c0 + c1), 64'd0);

    busCycle(24'hFC0000, 0, 1, 1, 0, 0, -1, ackE, ackD, fSeq, aSeen, c0, c1);
    chk("write_no_ack", 64'(ackE), 64'd0);
    chk("write_strobes", 64'(c0 + c1), 64'd0);

    for (int t = 0; t < 40; t++) begin
      hi   = ($urandom_range(0, 3) != 0) ? 8'hFC : 8'($urandom_range(0, 255));
      ra   = {hi, 16'($urandom)};
      ra[0] = 1'b0;
      rnwR = ($urandom_range(0, 4) != 0);
      uR   = 1'($urandom_range(0, 1));
      lR   = 1'($urandom_range(0, 1));
      if (!uR && !lR && $urandom_range(0, 3) != 0) uR = 1'b1;
      vaR  = 1'($urandom_range(0, 1));
      abR  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      busCycle(ra, rnwR, uR, lR, vaR, abR, -1, ackE, ackD, fSeq, aSeen, c0, c1);
    end

    vidActive = 1'b0;
    @(posedge pixClk);
    #1;
    cpuAddr = 23'h7E091A;
    cpuRnW  = 1'b1;
    ncpuAS  = 1'b0;
    ncpuUDS = 1'b0;
    ncpuLDS = 1'b0;
    repeat (6) @(negedge pixClk);
    #1;
    chk("pre_arst_ack", 64'(nDTACK), 64'd0);
    #5;
    nReset = 1'b0;
    #1;
    chk("arst_out", 64'({nDTACK, cpuDataOE, nrdOE}), 64'b101);
    chk("arst_data", 64'(cpuDataOut), 64'hFFFF);
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    repeat (3) @(negedge pixClk);
    @(posedge pixClk);
    #1;
    nReset = 1'b1;
    repeat (4) @(negedge pixClk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
